// File: rtl/seq_divmod_pkg.sv
// rtl/seq_divmod_pkg.sv - shared state type, counter sizing and error constants for seq_divmod
package seq_divmod_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int width_n);
      return (width_n > 1) ? $clog2(width_n) : 1;
   endfunction

   // Callers slice the low bits they need; a divide by zero reports all ones.
   function automatic logic [63:0] all_ones(input int width);
      return ~(64'hFFFF_FFFF_FFFF_FFFF << width);
   endfunction

endpackage

// File: rtl/seq_divmod_step.sv
// rtl/seq_divmod_step.sv - one combinational restoring-division iteration
module seq_divmod_step
   import seq_divmod_pkg::*;
#(
   parameter int WIDTH_D = 8
)
(
   input  logic [WIDTH_D:0]   rem_in,
   input  logic               bit_in,
   input  logic [WIDTH_D-1:0] den,
   output logic [WIDTH_D:0]   rem_out,
   output logic               q_bit
);

   logic [WIDTH_D+1:0] shifted;
   logic [WIDTH_D+1:0] trial;

   // One spare bit above the shifted remainder carries the borrow of the trial subtract.
   assign shifted = {rem_in, bit_in};
   assign trial   = shifted - {2'b00, den};
   assign q_bit   = ~trial[WIDTH_D+1];
   assign rem_out = q_bit ? trial[WIDTH_D:0] : shifted[WIDTH_D:0];

endmodule

// File: rtl/seq_divmod.sv
// rtl/seq_divmod.sv - iterative restoring divider with valid/ready handshakes; SEQ_DIVMOD_SIGNED_EN selects two's complement operands
module seq_divmod
   import seq_divmod_pkg::*;
#(
   parameter int WIDTH_N = 16,
   parameter int WIDTH_D = 8
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_N-1:0] numerator,
   input  logic [WIDTH_D-1:0] denominator,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_N-1:0] quotient,
   output logic [WIDTH_D-1:0] remainder,
   output logic               div_by_zero
);

   localparam int              CW       = cnt_width(WIDTH_N);
   localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH_N - 1);
   localparam logic [63:0]     ONES_N   = all_ones(WIDTH_N);
   localparam logic [63:0]     ONES_D   = all_ones(WIDTH_D);

   state_t             state;
   logic [CW-1:0]      count;
   logic [WIDTH_N-1:0] shreg;
   logic [WIDTH_D:0]   prem;
   logic [WIDTH_D-1:0] den_r;

   logic [WIDTH_D:0]   prem_next;
   logic               q_bit;
   logic [WIDTH_N-1:0] q_raw;
   logic [WIDTH_N-1:0] q_final;
   logic [WIDTH_D-1:0] r_final;
   logic [WIDTH_N-1:0] num_mag;
   logic [WIDTH_D-1:0] den_mag;

   seq_divmod_step #(
      .WIDTH_D (WIDTH_D)
   ) u_step (
      .rem_in  (prem),
      .bit_in  (shreg[WIDTH_N-1]),
      .den     (den_r),
      .rem_out (prem_next),
      .q_bit   (q_bit)
   );

   // Numerator bits leave at the top of shreg while quotient bits enter at the bottom.
   assign q_raw = {shreg[WIDTH_N-2:0], q_bit};

`ifdef SEQ_DIVMOD_SIGNED_EN
   logic neg_q;
   logic neg_r;

   assign num_mag = numerator[WIDTH_N-1] ? -numerator : numerator;
   assign den_mag = denominator[WIDTH_D-1] ? -denominator : denominator;
   assign q_final = neg_q ? -q_raw : q_raw;
   assign r_final = neg_r ? -prem_next[WIDTH_D-1:0] : prem_next[WIDTH_D-1:0];
`else
   assign num_mag = numerator;
   assign den_mag = denominator;
   assign q_final = q_raw;
   assign r_final = prem_next[WIDTH_D-1:0];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         count       <= '0;
         shreg       <= '0;
         prem        <= '0;
         den_r       <= '0;
`ifdef SEQ_DIVMOD_SIGNED_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (denominator == '0) begin
                     state       <= DONE;
                     out_valid   <= 1'b1;
                     quotient    <= ONES_N[WIDTH_N-1:0];
                     remainder   <= ONES_D[WIDTH_D-1:0];
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= CALC;
                     shreg <= num_mag;
                     den_r <= den_mag;
                     prem  <= '0;
                     count <= CNT_INIT;
`ifdef SEQ_DIVMOD_SIGNED_EN
                     neg_q <= numerator[WIDTH_N-1] ^ denominator[WIDTH_D-1];
                     neg_r <= numerator[WIDTH_N-1];
`endif
                  end
               end
            end
            CALC: begin
               shreg <= q_raw;
               prem  <= prem_next;
               count <= count - CW'(1);
               if (count == '0) begin
                  state       <= DONE;
                  out_valid   <= 1'b1;
                  quotient    <= q_final;
                  remainder   <= r_final;
                  div_by_zero <= 1'b0;
               end
            end
            DONE: begin
               // Result registers hold after the handshake; only the flags move.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divmod.sv
// tb/tb_seq_divmod.sv - directed self-checking bench for seq_divmod
module tb_seq_divmod;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] numerator;
   logic [7:0]  denominator;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;

   seq_divmod #(
      .WIDTH_N (16),
      .WIDTH_D (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .numerator   (numerator),
      .denominator (denominator),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Presents one operation and waits for out_valid; completes the handshake if out_ready is high.
   task automatic do_op(input string tag, input logic [15:0] num, input logic [7:0] den,
                        input logic [15:0] exp_q, input logic [7:0] exp_r,
                        input logic exp_dbz, input int exp_lat);
      int lat;
      check({tag, "_in_ready"}, in_ready, 1);
      numerator   = num;
      denominator = den;
      in_valid    = 1'b1;
      lat = 0;
      while (lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         in_valid = 1'b0;
         if (out_valid) break;
      end
      check({tag, "_out_valid"}, out_valid, 1);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_quotient"}, quotient, exp_q);
      check({tag, "_remainder"}, remainder, exp_r);
      check({tag, "_dbz"}, div_by_zero, exp_dbz);
      if (out_ready) begin
         @(posedge clk);
         #1;
         check({tag, "_released"}, out_valid, 0);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      numerator   = '0;
      denominator = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_op("basic", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17);
      do_op("dbz", 16'h1234, 8'd0, 16'hFFFF, 8'hFF, 1'b1, 1);
      do_op("max_by_1", 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, 17);
      do_op("small_num", 16'd5, 8'd200, 16'd0, 8'd5, 1'b0, 17);
`ifndef SEQ_DIVMOD_SIGNED_EN
      do_op("max_by_ff", 16'hFFFF, 8'hFF, 16'h0101, 8'd0, 1'b0, 17);
`endif

      out_ready = 1'b0;
      do_op("bp", 16'd500, 8'd9, 16'd55, 8'd5, 1'b0, 17);
      for (int i = 0; i < 10; i++) begin
         numerator   = 16'd77 + 16'(i);
         denominator = 8'd3;
         in_valid    = i[0];
         @(posedge clk);
         #1;
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_quotient", quotient, 16'd55);
         check("bp_remainder", remainder, 8'd5);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_drop_valid", out_valid, 0);
      check("bp_back_ready", in_ready, 1);
      check("bp_hold_quotient", quotient, 16'd55);
      repeat (20) @(posedge clk);
      #1;
      check("bp_no_ghost_op", out_valid, 0);

      numerator   = 16'd1000;
      denominator = 8'd7;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("abort_in_calc", in_ready, 0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_quotient", quotient, 0);
      check("abort_remainder", remainder, 0);
      check("abort_dbz", div_by_zero, 0);
      repeat (20) @(posedge clk);
      #1;
      check("abort_discarded", out_valid, 0);
      do_op("after_abort", 16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 17);

`ifdef SEQ_DIVMOD_SIGNED_EN
      do_op("s_neg_num", 16'hFFF9, 8'h02, 16'hFFFD, 8'hFF, 1'b0, 17);
      do_op("s_neg_den", 16'h0007, 8'hFE, 16'hFFFD, 8'h01, 1'b0, 17);
      do_op("s_overflow", 16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, 17);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_divmod.md
Name: seq_divmod

Overview:
- Parametrised, iterative (one quotient bit per cycle) restoring divider.
- Replaces the combinational divide/modulo path with a multi-cycle unit that has valid/ready handshakes on input and output.
- Produces quotient and remainder from a single operation.
- Keeps the established divide-by-zero convention: all-ones quotient and all-ones remainder.
- Sits between operand staging logic and the result consumer; one operation in flight at a time.

Parameters:
- WIDTH_N, 16, numerator and quotient width (>=2).
- WIDTH_D, 8, denominator and remainder width (>=1, <=WIDTH_N).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  unit can accept operands.
- numerator  input  WIDTH_N  dividend.
- denominator  input  WIDTH_D  divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH_N  numerator / denominator.
- remainder  output  WIDTH_D  numerator % denominator.
- div_by_zero  output  1  result came from a zero denominator.

Behaviour:
- One clock domain. Reset is synchronous, active-low, sampled on the clk rising edge.

Reset (rst_n low at an edge):
- State goes to IDLE; in_ready=1; out_valid=0.
- quotient=0, remainder=0, div_by_zero=0.
- Internal counter and partial remainder are cleared.
- Reset mid-CALC or mid-DONE aborts the operation; the result is discarded and never presented.

State machine (IDLE, CALC, DONE):
- IDLE: in_ready=1. On in_valid&&in_ready, capture the operands.
  - If denominator==0: go to DONE next cycle with quotient='1, remainder='1, div_by_zero=1 (latency 1).
  - Otherwise load the shift register with the numerator, clear the partial remainder, set count=WIDTH_N-1, and go to CALC.
- CALC: in_ready=0. Each cycle:
  - Shift the next MSB of the numerator into the partial remainder (WIDTH_D+1 bits wide).
  - Trial-subtract the denominator. If non-negative, keep the difference and set the quotient bit to 1; else restore and set it to 0.
  - After the iteration with count==0, go to DONE.
  - Total CALC cycles = WIDTH_N; acceptance-to-out_valid latency = WIDTH_N+1.
- DONE: out_valid=1. Outputs are held stable while out_valid&&!out_ready (no change, no drop).
  - On out_ready: go to IDLE; out_valid=0 next cycle; quotient, remainder and div_by_zero keep their last values.

Handshake rules:
- in_ready depends only on state, never combinationally on in_valid.
- No acceptance is possible in the same cycle as a DONE handshake; one bubble cycle separates operations.
- in_valid is ignored outside IDLE. Operand changes during CALC have no effect.

Arithmetic:
- Unsigned by default.
- Remainder < denominator always, so it fits in WIDTH_D.
- Numerator < denominator gives quotient=0, remainder=numerator.

Optional Feature:
- Macro: SEQ_DIVMOD_SIGNED_EN.
- Defined: the operands are two's complement.
  - The core operates on magnitudes; the sign is fixed up in DONE entry (same latency).
  - Quotient truncates toward zero; the remainder takes the sign of the numerator.
  - Overflow case (most-negative numerator / -1): quotient = most-negative value (wraps), remainder=0, div_by_zero=0.
  - Divide-by-zero is unchanged: all ones.
- Undefined: purely unsigned; no sign logic is synthesised.

Decomposition:
- Package seq_divmod_pkg holds:
  - state enum typedef (IDLE, CALC, DONE);
  - localparam function for counter width ($clog2(WIDTH_N));
  - all-ones error constant helper.
- Sub-module seq_divmod_step: purely combinational single restoring iteration. Inputs are partial remainder, incoming bit and denominator; outputs are next partial remainder and quotient bit.
- The top level holds the FSM, counter, registers and handshake.

Test Plan:
- Basic: 1000/7 (defaults) -> after 17 cycles out_valid, quotient=142, remainder=6, div_by_zero=0.
- Divide-by-zero: 0x1234/0 -> out_valid 1 cycle after acceptance, quotient=0xFFFF, remainder=0xFF, div_by_zero=1.
- Bounds:
  - 0xFFFF/1 -> quotient=0xFFFF, remainder=0.
  - 5/200 -> quotient=0, remainder=5.
  - 0xFFFF/0xFF -> quotient=0x0101, remainder=0.
- Backpressure: hold out_ready=0 for 10 cycles after result -> outputs stable, in_ready=0 throughout; new in_valid pulses are ignored.
- Reset mid-operation: assert rst_n=0 at CALC cycle 5 -> next cycle in_ready=1, out_valid=0, all outputs 0; a following 100/10 yields 10 r 0.
- SEQ_DIVMOD_SIGNED_EN:
  - -7/2 -> quotient=-3, remainder=-1.
  - 7/-2 -> quotient=-3, remainder=1.
  - -32768/-1 -> quotient=-32768, remainder=0.
